// File: rtl/ps2_command_assembler.sv
// PS/2 set-2 scan-code decoder that assembles ASCII characters into a
// right-justified command word and hands it to the processor via valid/ready.
module ps2_command_assembler #(
  parameter int CHARS       = 4,
  parameter int CHAR_W      = 8,
  parameter int AUTO_COMMIT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                scan_code,
  input  logic                      scan_valid,
  input  logic                      cmd_ready,
  output logic [CHARS*CHAR_W-1:0]   cmd_word,
  output logic                      cmd_valid,
  output logic [7:0]                char_ascii,
  output logic                      char_strobe,
  output logic                      drop_err
);

  localparam int W  = CHARS * CHAR_W;
  localparam int CW = $clog2(CHARS + 1);
  localparam logic [CW-1:0] FULL = CW'(CHARS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  typedef enum logic [1:0] {KEY_NONE, KEY_CHAR, KEY_COMMIT, KEY_DELETE} key_t;

  state_t          state_q, state_d;
  logic [7:0]      held_q, held_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    cmd_word_q, cmd_word_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      char_ascii_q, char_ascii_d;
  logic            char_strobe_q, char_strobe_d;
  logic            drop_err_q, drop_err_d;

  key_t            key_kind;
  logic [7:0]      key_ascii;
  logic            make_evt;
  logic [W-1:0]    buf_upd;
  logic [CW-1:0]   count_upd;
  logic            enter_req;
  logic            commit_req;
  logic            out_free;

  // Set-2 make code to ASCII classification.
  always_comb begin
    key_kind  = KEY_CHAR;
    key_ascii = 8'h00;
    case (scan_code)
      8'h1C: key_ascii = 8'h41;  8'h32: key_ascii = 8'h42;
      8'h21: key_ascii = 8'h43;  8'h23: key_ascii = 8'h44;
      8'h24: key_ascii = 8'h45;  8'h2B: key_ascii = 8'h46;
      8'h34: key_ascii = 8'h47;  8'h33: key_ascii = 8'h48;
      8'h43: key_ascii = 8'h49;  8'h3B: key_ascii = 8'h4A;
      8'h42: key_ascii = 8'h4B;  8'h4B: key_ascii = 8'h4C;
      8'h3A: key_ascii = 8'h4D;  8'h31: key_ascii = 8'h4E;
      8'h44: key_ascii = 8'h4F;  8'h4D: key_ascii = 8'h50;
      8'h15: key_ascii = 8'h51;  8'h2D: key_ascii = 8'h52;
      8'h1B: key_ascii = 8'h53;  8'h2C: key_ascii = 8'h54;
      8'h3C: key_ascii = 8'h55;  8'h2A: key_ascii = 8'h56;
      8'h1D: key_ascii = 8'h57;  8'h22: key_ascii = 8'h58;
      8'h35: key_ascii = 8'h59;  8'h1A: key_ascii = 8'h5A;
      8'h45: key_ascii = 8'h30;  8'h16: key_ascii = 8'h31;
      8'h1E: key_ascii = 8'h32;  8'h26: key_ascii = 8'h33;
      8'h25: key_ascii = 8'h34;  8'h2E: key_ascii = 8'h35;
      8'h36: key_ascii = 8'h36;  8'h3D: key_ascii = 8'h37;
      8'h3E: key_ascii = 8'h38;  8'h46: key_ascii = 8'h39;
      8'h29: key_ascii = 8'h20;
      8'h5A: key_kind  = KEY_COMMIT;
      8'h66: key_kind  = KEY_DELETE;
      default: key_kind = KEY_NONE;
    endcase
  end

  // Prefix decoder; only plain make codes that differ from the held key
  // reach the character logic, which is how typematic repeats are dropped.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    make_evt = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hF0) begin
            state_d = BRK;
          end else if (scan_code == 8'hE0) begin
            state_d = EXT;
          end else if (scan_code != held_q) begin
            held_d   = scan_code;
            make_evt = 1'b1;
          end
        end
        BRK: begin
          if (scan_code == held_q) held_d = 8'h00;
          state_d = IDLE;
        end
        EXT: begin
          state_d = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer update followed by the commit decision, which sees the updated
  // buffer so a fourth character can commit in the same cycle.
  always_comb begin
    buf_upd       = buf_q;
    count_upd     = count_q;
    char_ascii_d  = char_ascii_q;
    char_strobe_d = 1'b0;
    drop_err_d    = 1'b0;
    enter_req     = 1'b0;
    if (make_evt) begin
      case (key_kind)
        KEY_CHAR: begin
          if (count_q < FULL) begin
            buf_upd       = (buf_q << CHAR_W) | W'(key_ascii);
            count_upd     = count_q + ONE;
            char_ascii_d  = key_ascii;
            char_strobe_d = 1'b1;
          end else begin
            drop_err_d = 1'b1;
          end
        end
        KEY_DELETE: begin
          if (count_q != '0) begin
            buf_upd   = buf_q >> CHAR_W;
            count_upd = count_q - ONE;
          end
        end
        KEY_COMMIT: enter_req = (count_q != '0);
        default: ;
      endcase
    end

    commit_req  = enter_req || ((AUTO_COMMIT != 0) && (count_upd == FULL));
    out_free    = !cmd_valid_q || cmd_ready;
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    cmd_word_d  = cmd_word_q;
    buf_d       = buf_upd;
    count_d     = count_upd;
    if (commit_req && out_free) begin
      cmd_word_d  = buf_upd;
      cmd_valid_d = 1'b1;
      buf_d       = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      held_q        <= 8'h00;
      buf_q         <= '0;
      count_q       <= '0;
      cmd_word_q    <= '0;
      cmd_valid_q   <= 1'b0;
      char_ascii_q  <= 8'h00;
      char_strobe_q <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      buf_q         <= buf_d;
      count_q       <= count_d;
      cmd_word_q    <= cmd_word_d;
      cmd_valid_q   <= cmd_valid_d;
      char_ascii_q  <= char_ascii_d;
      char_strobe_q <= char_strobe_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign cmd_word    = cmd_word_q;
  assign cmd_valid   = cmd_valid_q;
  assign char_ascii  = char_ascii_q;
  assign char_strobe = char_strobe_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_ps2_command_assembler.sv
// Directed bench for ps2_command_assembler: bytes are driven on the falling
// edge and the registered outputs are checked on the following falling edge.
module tb_ps2_command_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic [7:0]  char_ascii;
  logic        char_strobe;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  ps2_command_assembler #(.CHARS(4), .CHAR_W(8), .AUTO_COMMIT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .cmd_ready   (cmd_ready),
    .cmd_word    (cmd_word),
    .cmd_valid   (cmd_valid),
    .char_ascii  (char_ascii),
    .char_strobe (char_strobe),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte strobe; on return the outputs reflect that byte.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; scan_code = 8'h00; scan_valid = 1'b0; cmd_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    checkOutput("rst_word", cmd_word, 32'h0);
    checkOutput("rst_valid", {31'b0, cmd_valid}, 32'h0);
    checkOutput("rst_ascii", {24'b0, char_ascii}, 32'h0);
    checkOutput("rst_strobe", {31'b0, char_strobe}, 32'h0);
    checkOutput("rst_drop", {31'b0, drop_err}, 32'h0);

    // D, F, Enter with the processor stalled
    applyStimulus(8'h23);
    checkOutput("t1_strobe_d", {31'b0, char_strobe}, 32'h1);
    checkOutput("t1_ascii_d", {24'b0, char_ascii}, 32'h44);
    applyStimulus(8'hF0);
    applyStimulus(8'h23);
    checkOutput("t1_brk_nostrobe", {31'b0, char_strobe}, 32'h0);
    applyStimulus(8'h2B);
    checkOutput("t1_strobe_f", {31'b0, char_strobe}, 32'h1);
    checkOutput("t1_ascii_f", {24'b0, char_ascii}, 32'h46);
    applyStimulus(8'hF0);
    applyStimulus(8'h2B);
    applyStimulus(8'h5A);
    checkOutput("t1_valid", {31'b0, cmd_valid}, 32'h1);
    checkOutput("t1_word", cmd_word, 32'h00004446);
    applyStimulus(8'hF0);
    applyStimulus(8'h5A);
    idle(3);
    checkOutput("t1_valid_held", {31'b0, cmd_valid}, 32'h1);
    checkOutput("t1_word_held", cmd_word, 32'h00004446);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("t1_valid_drop", {31'b0, cmd_valid}, 32'h0);

    // Typematic repeat of A yields one character
    applyStimulus(8'h1C);
    checkOutput("t2_strobe1", {31'b0, char_strobe}, 32'h1);
    checkOutput("t2_ascii", {24'b0, char_ascii}, 32'h41);
    applyStimulus(8'h1C);
    checkOutput("t2_rep1", {31'b0, char_strobe}, 32'h0);
    applyStimulus(8'h1C);
    checkOutput("t2_rep2", {31'b0, char_strobe}, 32'h0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    applyStimulus(8'h5A);
    checkOutput("t2_word", cmd_word, 32'h00000041);
    checkOutput("t2_valid", {31'b0, cmd_valid}, 32'h1);
    cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2_drain", {31'b0, cmd_valid}, 32'h0);

    // Auto-commit on the fourth character with ready high
    applyStimulus(8'h2B);
    applyStimulus(8'h23);
    applyStimulus(8'h26);
    checkOutput("t3_not_yet", {31'b0, cmd_valid}, 32'h0);
    applyStimulus(8'h45);
    checkOutput("t3_valid", {31'b0, cmd_valid}, 32'h1);
    checkOutput("t3_word", cmd_word, 32'h46443330);
    @(negedge clk);
    checkOutput("t3_valid_low", {31'b0, cmd_valid}, 32'h0);
    applyStimulus(8'h5A);
    checkOutput("t3_empty_enter", {31'b0, cmd_valid}, 32'h0);

    // Full buffer blocked by a stalled output, then an overflow
    cmd_ready = 1'b0;
    applyStimulus(8'h1C); applyStimulus(8'h32); applyStimulus(8'h21); applyStimulus(8'h23);
    checkOutput("t4_word1", cmd_word, 32'h41424344);
    applyStimulus(8'h24); applyStimulus(8'h2B); applyStimulus(8'h34); applyStimulus(8'h33);
    checkOutput("t4_h_strobe", {31'b0, char_strobe}, 32'h1);
    checkOutput("t4_word1_kept", cmd_word, 32'h41424344);
    applyStimulus(8'h2D);
    checkOutput("t4_drop", {31'b0, drop_err}, 32'h1);
    checkOutput("t4_drop_nostrobe", {31'b0, char_strobe}, 32'h0);
    @(negedge clk);
    checkOutput("t4_drop_pulse", {31'b0, drop_err}, 32'h0);
    checkOutput("t4_word_stable", cmd_word, 32'h41424344);
    cmd_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_word2", cmd_word, 32'h45464748);
    checkOutput("t4_valid_stays", {31'b0, cmd_valid}, 32'h1);
    @(negedge clk);
    checkOutput("t4_valid_low", {31'b0, cmd_valid}, 32'h0);
    idle(2);
    checkOutput("t4_no_retrigger", {31'b0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;
    applyStimulus(8'h5A);
    checkOutput("t4_buf_empty", {31'b0, cmd_valid}, 32'h0);

    // Backspace plus ignored extended sequences
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h66);
    checkOutput("t5_bs_nostrobe", {31'b0, char_strobe}, 32'h0);
    applyStimulus(8'hE0); applyStimulus(8'h75);
    checkOutput("t5_ext_nostrobe", {31'b0, char_strobe}, 32'h0);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    applyStimulus(8'h21);
    checkOutput("t5_ascii_c", {24'b0, char_ascii}, 32'h43);
    applyStimulus(8'hE0); applyStimulus(8'h5A);
    checkOutput("t5_ext_enter", {31'b0, cmd_valid}, 32'h0);
    applyStimulus(8'h5A);
    checkOutput("t5_word", cmd_word, 32'h00004143);
    checkOutput("t5_valid", {31'b0, cmd_valid}, 32'h1);

    // Reset in the middle of a break prefix
    applyStimulus(8'hF0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6_word", cmd_word, 32'h0);
    checkOutput("t6_valid", {31'b0, cmd_valid}, 32'h0);
    checkOutput("t6_ascii", {24'b0, char_ascii}, 32'h0);
    applyStimulus(8'h1C);
    checkOutput("t6_make_strobe", {31'b0, char_strobe}, 32'h1);
    checkOutput("t6_make_ascii", {24'b0, char_ascii}, 32'h41);
    applyStimulus(8'h5A);
    checkOutput("t6_commit", cmd_word, 32'h00000041);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
